// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings (htrans, hburst, hsize, hresp), line-fill FSM state type and burst-code helper
package ahb_pkg;
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [2:0] {IDLE, ADDR, BURST, DRAIN, DONE} fill_state_t;
  function automatic logic [2:0] burst_code(input int words, input logic wrap);
    return words == 16 ? (wrap ? HBURST_WRAP16 : HBURST_INCR16) :
           words == 8  ? (wrap ? HBURST_WRAP8  : HBURST_INCR8)  :
                         (wrap ? HBURST_WRAP4  : HBURST_INCR4);
  endfunction
endpackage

// File: rtl/fill_line_buffer.sv
// fill_line_buffer: LINE_WORDS x DATA_WIDTH line registers; ports clk, rst (async active-low), we/idx/wdata word write, flat line_data out
module fill_line_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             we,
  input  logic [$clog2(LINE_WORDS)-1:0]    idx,
  input  logic [DATA_WIDTH-1:0]            wdata,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] line_data
);
  logic [DATA_WIDTH-1:0] words [LINE_WORDS];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) words <= '{default: '0};
    else if (we) words[idx] <= wdata;
  end
  for (genvar i = 0; i < LINE_WORDS; i++) begin : g_flat
    assign line_data[i*DATA_WIDTH +: DATA_WIDTH] = words[i];
  end
endmodule

// File: rtl/ahb_line_fill_master.sv
// ahb_line_fill_master: AHB-Lite burst line fill for the I-cache; in: clk, rst (async active-low), mem_req, req_addr, hrdata, hready, hresp; out: mem_ready, line_data, bus_err, haddr, htrans, hburst, hsize, hwrite; option CACHE_CRIT_WORD_FIRST_EN selects WRAPn critical-word-first
module ahb_line_fill_master
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             mem_req,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  output logic                             mem_ready,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] line_data,
  output logic                             bus_err,
  output logic [ADDR_WIDTH-1:0]            haddr,
  output logic [1:0]                       htrans,
  output logic [2:0]                       hburst,
  output logic [2:0]                       hsize,
  output logic                             hwrite,
  input  logic [DATA_WIDTH-1:0]            hrdata,
  input  logic                             hready,
  input  logic                             hresp
);
  localparam int IW = $clog2(LINE_WORDS);
  localparam int LB = IW + 2;
  localparam int CW = IW + 1;
  fill_state_t           state;
  logic [CW-1:0]         addr_cnt;
  logic [CW-1:0]         data_cnt;
  logic                  dph_valid;
  logic [IW-1:0]         dph_idx;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  addr_acc;
  logic                  data_ok;
  logic                  err;
  logic                  last_addr;
  logic                  last_data;
`ifdef CACHE_CRIT_WORD_FIRST_EN
  localparam logic WRAP = 1'b1;
  assign base      = req_addr & ~ADDR_WIDTH'(3);
  assign next_addr = {haddr[ADDR_WIDTH-1:LB], haddr[LB-1:2] + IW'(1), 2'b00};
`else
  localparam logic WRAP = 1'b0;
  assign base      = req_addr & ~ADDR_WIDTH'(LINE_WORDS*4-1);
  assign next_addr = haddr + ADDR_WIDTH'(4);
`endif
  assign hsize     = HSIZE_WORD;
  assign hwrite    = 1'b0;
  assign addr_acc  = htrans[1] && hready;
  assign data_ok   = dph_valid && hready && hresp == HRESP_OKAY;
  assign err       = dph_valid && hresp == HRESP_ERROR;
  assign last_addr = addr_cnt == CW'(LINE_WORDS-1);
  assign last_data = data_cnt == CW'(LINE_WORDS-1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      htrans    <= HTRANS_IDLE;
      haddr     <= '0;
      hburst    <= '0;
      mem_ready <= 1'b0;
      bus_err   <= 1'b0;
      addr_cnt  <= '0;
      data_cnt  <= '0;
      dph_valid <= 1'b0;
      dph_idx   <= '0;
    end else begin
      if (hready) begin
        dph_valid <= htrans[1];
        dph_idx   <= haddr[LB-1:2];
      end
      if (addr_acc) addr_cnt <= addr_cnt + CW'(1);
      if (data_ok) data_cnt <= data_cnt + CW'(1);
      case (state)
        IDLE: if (mem_req) begin
          state    <= ADDR;
          htrans   <= HTRANS_NONSEQ;
          haddr    <= base;
          hburst   <= burst_code(LINE_WORDS, WRAP);
          addr_cnt <= '0;
          data_cnt <= '0;
        end
        ADDR: if (hready) begin
          state  <= BURST;
          htrans <= HTRANS_SEQ;
          haddr  <= next_addr;
        end
        BURST: if (err) begin
          htrans    <= HTRANS_IDLE;
          state     <= hready ? DONE : DRAIN;
          mem_ready <= hready;
          bus_err   <= hready;
        end else if (hready) begin
          htrans <= last_addr ? HTRANS_IDLE : HTRANS_SEQ;
          haddr  <= last_addr ? haddr : next_addr;
          state  <= last_addr ? DRAIN : BURST;
        end
        DRAIN: if (dph_valid && hready && (hresp == HRESP_ERROR || last_data)) begin
          state     <= DONE;
          mem_ready <= 1'b1;
          bus_err   <= hresp == HRESP_ERROR;
        end
        DONE: begin
          state     <= IDLE;
          mem_ready <= 1'b0;
          bus_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  fill_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .LINE_WORDS(LINE_WORDS)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .we        (data_ok),
    .idx       (dph_idx),
    .wdata     (hrdata),
    .line_data (line_data)
  );
endmodule

// File: tb/tb_ahb_line_fill_master.sv
// tb_ahb_line_fill_master: table-driven fills against an AHB slave model with a scoreboard of expected lines, plus reset and back-to-back sequences
module tb_ahb_line_fill_master;
  logic         clk;
  logic         rst;
  logic         mem_req;
  logic [31:0]  req_addr;
  logic         mem_ready;
  logic [127:0] line_data;
  logic         bus_err;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic [2:0]   hburst;
  logic [2:0]   hsize;
  logic         hwrite;
  logic [31:0]  hrdata;
  logic         hready;
  logic         hresp;
  typedef struct {
    logic [31:0] addr;
    int          wait_beat;
    int          wait_n;
    int          err_beat;
    bit          exp_err;
    int          exp_lat;
    int          poke;
    bit          hold;
  } vec_t;
  typedef struct {
    logic [127:0] line;
    logic         err;
    int           lat;
  } exp_t;
`ifdef CACHE_CRIT_WORD_FIRST_EN
  localparam logic [2:0] EXP_BURST = 3'b010;
`else
  localparam logic [2:0] EXP_BURST = 3'b011;
`endif
  int         checks;
  int         errors;
  logic [7:0] salt;
  exp_t       sb[$];
  vec_t       vecs[9];
  vec_t       hv;
  int         seen;
  ahb_line_fill_master dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .req_addr  (req_addr),
    .mem_ready (mem_ready),
    .line_data (line_data),
    .bus_err   (bus_err),
    .haddr     (haddr),
    .htrans    (htrans),
    .hburst    (hburst),
    .hsize     (hsize),
    .hwrite    (hwrite),
    .hrdata    (hrdata),
    .hready    (hready),
    .hresp     (hresp)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction
  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {salt, a[23:0]} ^ 32'h00A5_5A00;
  endfunction
  function automatic logic [31:0] exp_addr(input logic [31:0] a, input int k);
    logic [31:0] r;
`ifdef CACHE_CRIT_WORD_FIRST_EN
    r = a & ~32'h3;
    r[3:2] = r[3:2] + 2'(k);
`else
    r = (a & ~32'hF) + 32'(4 * k);
`endif
    return r;
  endfunction
  task automatic run_fill(input vec_t v);
    exp_t        e;
    int          n, na, nd, wcnt, ecnt, bad_idle, exp_na;
    logic        dph, hold_prev, after_err, fin;
    logic [31:0] dph_addr, a, cur_addr;
    logic [1:0]  cur_trans;
    salt++;
    e.line = '0;
    for (int k = 0; k < 4; k++) begin
      a = exp_addr(v.addr, k);
      e.line[32*int'(a[3:2]) +: 32] = data_of(a);
    end
    e.err = v.exp_err;
    e.lat = v.exp_lat;
    sb.push_back(e);
    mem_req = 1'b1;
    req_addr = v.addr;
    hready = 1'b1;
    hresp = 1'b0;
    hrdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    if (!v.hold) mem_req = 1'b0;
    n = 0; na = 0; nd = 0; wcnt = 0; ecnt = 0; bad_idle = 0;
    dph = 1'b0; hold_prev = 1'b0; after_err = 1'b0; fin = 1'b0;
    dph_addr = '0; cur_addr = '0; cur_trans = '0;
    while (!fin) begin
      if (hold_prev) begin
        chk("hold_haddr", haddr, cur_addr);
        chk("hold_htrans", htrans, cur_trans);
      end
      if (after_err && htrans != 2'b00) bad_idle++;
      if (mem_ready) begin
        fin = 1'b1;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty actual=mem_ready required=no_pulse");
        end else begin
          e = sb.pop_front();
          chk("latency", n, e.lat);
          chk("bus_err", bus_err, e.err);
          if (!e.err) chk("line_data", line_data, e.line);
        end
      end else if (n >= 40) begin
        fin = 1'b1;
        checks++;
        errors++;
        $display("FAIL timeout actual=no_mem_ready required=mem_ready_within_40");
        if (sb.size() > 0) e = sb.pop_back();
      end else begin
        if (v.poke >= 0 && n == v.poke) begin
          mem_req = 1'b1;
          req_addr = 32'h0000_2000;
        end
        if (v.poke >= 0 && n == v.poke + 1) mem_req = 1'b0;
        hready = 1'b1;
        hresp = 1'b0;
        hrdata = 32'hDEAD_BEEF;
        if (dph) begin
          if (nd == v.err_beat) begin
            hresp = 1'b1;
            hready = (ecnt == 1);
            ecnt++;
          end else if (nd == v.wait_beat && wcnt < v.wait_n) begin
            hready = 1'b0;
            wcnt++;
          end else hrdata = data_of(dph_addr);
        end
        if (htrans[1] && hready) begin
          chk("haddr", haddr, exp_addr(v.addr, na));
          chk("htrans", htrans, na == 0 ? 2'b10 : 2'b11);
          chk("hburst", hburst, EXP_BURST);
          na++;
        end
        hold_prev = htrans[1] && !hready && !hresp;
        cur_addr = haddr;
        cur_trans = htrans;
        @(posedge clk);
        if (dph && hready && !hresp) nd++;
        if (dph && hresp && !hready) after_err = 1'b1;
        if (hready) begin
          dph = cur_trans[1];
          dph_addr = cur_addr;
        end
        #1;
        n++;
      end
    end
    exp_na = (v.err_beat < 0 || v.err_beat >= 3) ? 4 : v.err_beat + 1;
    chk("addr_beats", na, exp_na);
    if (v.err_beat >= 0) chk("no_seq_after_err", bad_idle, 0);
    else chk("data_beats", nd, 4);
    hready = 1'b1;
    hresp = 1'b0;
    hrdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    chk("ready_pulse", mem_ready, 0);
  endtask
  initial begin
    checks = 0;
    errors = 0;
    salt = 8'h00;
    rst = 1'b0;
    mem_req = 1'b0;
    req_addr = '0;
    hready = 1'b1;
    hresp = 1'b0;
    hrdata = '0;
    vecs[0] = '{32'h0000_1234, -1, 0, -1, 1'b0, 5, -1, 1'b0};
    vecs[1] = '{32'h0000_1234,  1, 2, -1, 1'b0, 7, -1, 1'b0};
    vecs[2] = '{32'h0000_1234, -1, 0,  2, 1'b1, 5, -1, 1'b0};
    vecs[3] = '{32'h0000_1230, -1, 0, -1, 1'b0, 5,  2, 1'b0};
    vecs[4] = '{32'h0000_1238, -1, 0, -1, 1'b0, 5, -1, 1'b0};
    vecs[5] = '{32'hFFFF_FFFC,  3, 3, -1, 1'b0, 8, -1, 1'b0};
    vecs[6] = '{32'h0000_0008, -1, 0,  0, 1'b1, 3, -1, 1'b0};
    vecs[7] = '{32'h8000_0004, -1, 0,  3, 1'b1, 6, -1, 1'b0};
    vecs[8] = '{32'h0000_5670,  0, 1, -1, 1'b0, 6, -1, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_htrans", htrans, 2'b00);
    chk("rst_haddr", haddr, 0);
    chk("rst_hburst", hburst, 0);
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_line_data", line_data, 0);
    chk("hsize", hsize, 3'b010);
    chk("hwrite", hwrite, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) run_fill(vecs[i]);
    hv = '{32'h0000_4444, -1, 0, -1, 1'b0, 5, -1, 1'b1};
    run_fill(hv);
    @(posedge clk);
    #1;
    chk("b2b_htrans", htrans, 2'b10);
    chk("b2b_haddr", haddr, exp_addr(32'h0000_4444, 0));
    mem_req = 1'b0;
    hready = 1'b1;
    hresp = 1'b0;
    hrdata = 32'h1111_2222;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_htrans", htrans, 2'b00);
    chk("midrst_haddr", haddr, 0);
    chk("midrst_hburst", hburst, 0);
    chk("midrst_line_data", line_data, 0);
    chk("midrst_mem_ready", mem_ready, 0);
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (mem_ready) seen++;
    end
    rst = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (mem_ready) seen++;
    end
    chk("no_ready_after_rst", seen, 0);
    chk("idle_after_rst", htrans, 2'b00);
    hv = '{32'h0000_1234, -1, 0, -1, 1'b0, 5, -1, 1'b0};
    run_fill(hv);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
